// File: rtl/bound_flasher_pkg.sv
// Shared types and lamp-bar bound constants for the bound flasher.
// Imported by the controller and by anything that inspects its state.
package bound_flasher_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UP15,
        DOWN5,
        UP10,
        DOWN0,
        UP5,
        DOWNF,
        KB0
    } state_t;

    localparam logic [15:0] LED_ALL  = 16'hFFFF;
    localparam logic [15:0] LED_L5   = 16'h003F;
    localparam logic [15:0] LED_L4   = 16'h001F;
    localparam logic [15:0] LED_L10  = 16'h07FF;
    localparam logic [15:0] LED_ZERO = 16'h0000;
    localparam logic [15:0] LED_ONE  = 16'h0001;

endpackage

// File: rtl/bound_flasher.sv
// Bound flasher: sweeps a thermometer lamp bar through fixed bounds.
// flick starts a sequence from idle and kicks back at lamps 5/10.
module bound_flasher
    import bound_flasher_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flick,
    output logic [15:0] led_state
);

    state_t      state;
    state_t      state_nx;
    logic [15:0] led_nx;
    logic [15:0] led_up;
    logic [15:0] led_dn;

    assign led_up = {led_state[14:0], 1'b1};
    assign led_dn = {1'b0, led_state[15:1]};

    // Next state and next lamp bar; kickback is checked before the step.
    always_comb begin
        state_nx = state;
        led_nx   = led_state;
        case (state)
            IDLE: begin
                if (flick) begin
                    led_nx   = LED_ONE;
                    state_nx = UP15;
                end else begin
                    led_nx   = LED_ZERO;
                end
            end
            UP15: begin
                if (flick && (led_state == LED_L5 ||
                              led_state == LED_L10)) begin
                    led_nx   = led_dn;
                    state_nx = KB0;
                end else begin
                    led_nx = led_up;
                    if (led_up == LED_ALL) state_nx = DOWN5;
                end
            end
            DOWN5: begin
                // Entered already at the lamp-5 bound after a kickback:
                // turn straight round into the up-sweep.
                if (led_state == LED_L4) begin
                    led_nx   = led_up;
                    state_nx = UP10;
                end else begin
                    led_nx = led_dn;
                    if (led_dn == LED_L4) state_nx = UP10;
                end
            end
            UP10: begin
                if (flick && led_state == LED_L5) begin
                    led_nx   = led_dn;
                    state_nx = DOWN5;
                end else begin
                    led_nx = led_up;
                    if (led_up == LED_L10) state_nx = DOWN0;
                end
            end
            DOWN0: begin
                if (flick && led_state == LED_L10) begin
                    led_nx   = led_dn;
                    state_nx = DOWN5;
                end else begin
                    led_nx = led_dn;
                    if (led_dn == LED_ZERO) state_nx = UP5;
                end
            end
            UP5: begin
                led_nx = led_up;
                if (led_up == LED_L5) state_nx = DOWNF;
            end
            DOWNF: begin
                led_nx = led_dn;
                if (led_dn == LED_ZERO) state_nx = IDLE;
            end
            KB0: begin
                led_nx = led_dn;
                if (led_dn == LED_ZERO) state_nx = UP15;
            end
            default: begin
                led_nx   = LED_ZERO;
                state_nx = IDLE;
            end
        endcase
    end

    // State and lamp bar registers; reset aborts any sweep at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            led_state <= LED_ZERO;
        end else begin
            state     <= state_nx;
            led_state <= led_nx;
        end
    end

endmodule

// File: tb/tb_bound_flasher.sv
// Self-checking bench for bound_flasher against a lamp-count model.
// The model tracks lit-lamp count and a phase table of sweep targets.
module tb_bound_flasher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flick = 1'b0;
    logic [15:0] led_state;

    int checks = 0;
    int fails  = 0;

    // Model: phase 0 idle, 1..6 normal sweeps, 7 kickback-to-zero.
    int m_phase = 0;
    int m_n     = 0;
    int tgt [8] = '{0, 16, 5, 11, 0, 6, 0, 0};
    int dir [8] = '{0, 1, -1, 1, -1, 1, -1, -1};
    int nxt [8] = '{0, 2, 3, 4, 5, 6, 0, 1};

    bound_flasher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flick     (flick),
        .led_state (led_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] m_led();
        logic [31:0] v;
        v = (32'd1 << m_n) - 32'd1;
        return v[15:0];
    endfunction

    function automatic void model_reset();
        m_phase = 0;
        m_n     = 0;
    endfunction

    function automatic void model_step(input logic f);
        bit k;
        k = (f === 1'b1);
        if (m_phase == 0) begin
            if (k) begin
                m_n     = 1;
                m_phase = 1;
            end
        end else if (m_phase == 1 && k && (m_n == 6 || m_n == 11)) begin
            m_n     = m_n - 1;
            m_phase = 7;
        end else if (m_phase == 3 && k && m_n == 6) begin
            m_n     = 5;
            m_phase = 2;
        end else if (m_phase == 4 && k && m_n == 11) begin
            m_n     = 10;
            m_phase = 2;
        end else begin
            if (m_n == tgt[m_phase]) m_phase = nxt[m_phase];
            m_n = m_n + dir[m_phase];
            if (m_n == tgt[m_phase]) m_phase = nxt[m_phase];
        end
    endfunction

    task automatic cycle(input logic f, input string tag);
        flick = f;
        @(posedge clk);
        if (rst_n) model_step(f);
        #1;
        checks++;
        if (led_state !== m_led()) begin
            fails++;
            $display("FAIL %s: led_state=%h expected=%h",
                     tag, led_state, m_led());
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 200;
        while (m_phase != 0 && budget > 0) begin
            cycle(1'b0, tag);
            budget--;
        end
        checks++;
        if (m_phase != 0) begin
            fails++;
            $display("FAIL %s_drain: model phase=%0d expected=0",
                     tag, m_phase);
        end
        cycle(1'b0, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, "reset_hold");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, "reset_idle");
    endtask

    task automatic test_x_idle();
        cycle(1'bx, "x_idle");
        cycle(1'bx, "x_idle");
        cycle(1'b0, "x_idle");
    endtask

    task automatic test_full_pass();
        int edges;
        int budget;
        cycle(1'b1, "full_pass");
        edges = 1;
        cycle(1'b1, "full_pass");
        edges++;
        cycle(1'b1, "full_pass");
        edges++;
        budget = 200;
        while (led_state !== 16'h0000 && budget > 0) begin
            cycle(1'b0, "full_pass");
            edges++;
            budget--;
        end
        // First zero is the DOWN0 floor; run on to the final zero.
        while ((led_state === 16'h0000) && budget > 0) begin
            cycle(1'b0, "full_pass");
            edges++;
            budget--;
        end
        while (led_state !== 16'h0000 && budget > 0) begin
            cycle(1'b0, "full_pass");
            edges++;
            budget--;
        end
        checks++;
        if (edges != 56) begin
            fails++;
            $display("FAIL full_pass_len: edges=%0d expected=56", edges);
        end
        cycle(1'b0, "full_pass_idle");
        cycle(1'b0, "full_pass_idle");
    endtask

    task automatic test_kick_l5();
        bit kicked;
        bit f;
        kicked = 0;
        cycle(1'b1, "kick_l5");
        for (int i = 0; i < 40; i++) begin
            f = (!kicked && m_phase == 1 && m_n == 6);
            if (f) kicked = 1;
            cycle(f, "kick_l5");
        end
        drain("kick_l5");
    endtask

    task automatic test_kick_l10();
        bit kicked;
        bit f;
        kicked = 0;
        cycle(1'b1, "kick_l10");
        for (int i = 0; i < 60; i++) begin
            f = (!kicked && m_phase == 4 && m_n == 11);
            if (f) kicked = 1;
            cycle(f, "kick_l10");
        end
        drain("kick_l10");
    endtask

    task automatic test_held_high();
        bit seen_all;
        seen_all = 0;
        for (int i = 0; i < 60; i++) begin
            cycle(1'b1, "held_high");
            if (led_state === 16'hFFFF) seen_all = 1;
        end
        checks++;
        if (seen_all) begin
            fails++;
            $display("FAIL held_high_peak: reached=1 expected=0");
        end
        drain("held_high");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++)
            cycle(logic'($urandom_range(0, 3) == 0), "random");
        drain("random");
    endtask

    task automatic test_async_reset();
        int budget;
        budget = 100;
        cycle(1'b1, "async_rst");
        while (!(m_phase == 1 && m_n == 12) && budget > 0) begin
            cycle(1'b0, "async_rst");
            budget--;
        end
        checks++;
        if (led_state !== 16'h0FFF) begin
            fails++;
            $display("FAIL async_rst_pre: led_state=%h expected=0fff",
                     led_state);
        end
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (led_state !== 16'h0000) begin
            fails++;
            $display("FAIL async_rst_now: led_state=%h expected=0000",
                     led_state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, "async_rst_idle");
        cycle(1'b1, "async_rst_restart");
        drain("async_rst_restart");
    endtask

    initial begin
        test_reset();
        test_x_idle();
        test_full_pass();
        test_kick_l5();
        test_kick_l10();
        test_held_high();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
